// File: rtl/score_target_controller_pkg.sv
// Shared definitions for the score/target game-logic stage.
// Holds the controller state encoding, the digit-range constants and the
// helper that folds a raw 4-bit random value into a new target digit.
package score_target_controller_pkg;

  localparam int unsigned NUM_DIGITS = 10;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned LFSR_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SCORED,
    COOLDOWN
  } state_e;

  // Fold 0..15 into 0..9 (10..15 map to 4..9), then step past the current digit
  // so a new target never repeats the old one.
  function automatic logic [DIGIT_W-1:0] pick_digit(input logic [DIGIT_W-1:0] raw,
                                                    input logic [DIGIT_W-1:0] cur);
    logic [DIGIT_W-1:0] c;
    c = raw;
    if (c >= DIGIT_W'(NUM_DIGITS)) c = c - DIGIT_W'(6);
    if (c == cur) c = (cur == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : cur + DIGIT_W'(1);
    return c;
  endfunction

endpackage

// File: rtl/random_digit.sv
// Pseudo-random next-target generator.
// Ports:
//   clk, reset      - pixel clock, synchronous active-high reset
//   cur_digit_i     - target digit currently shown
//   next_digit_o    - candidate next digit, 0..9 and != cur_digit_i
//                     (combinational from the registered LFSR)
module random_digit
  import score_target_controller_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] cur_digit_i,
  output logic [DIGIT_W-1:0] next_digit_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1; free-runs outside reset.
  assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign next_digit_o = pick_digit(lfsr_q[DIGIT_W-1:0], cur_digit_i);

endmodule

// File: rtl/score_target_controller.sv
// Target-digit and score controller for the obstacle digit row.
// Detects the ball touching the highlighted digit, keeps a saturating BCD
// score and retargets only at frame boundaries (after a hit or a timeout).
// Ports:
//   clk, reset              - pixel clock, synchronous active-high reset
//   startOfFrame            - one-cycle pulse at the first pixel of a frame
//   gameActive              - level; low freezes the game and returns to IDLE
//   clearScore              - one-cycle pulse; zeroes the score (beats a hit)
//   drawBall, drawScoreNumber - pixel ownership; both high is a collision
//   scoreNumber             - registered target digit 0..9
//   hitPulse                - registered one-cycle pulse per accepted hit
//   scoreTens, scoreOnes    - registered BCD score 00..99
module score_target_controller
  import score_target_controller_pkg::*;
#(
  parameter int unsigned       TARGET_FRAMES   = 300,
  parameter int unsigned       COOLDOWN_FRAMES = 30,
  parameter logic [LFSR_W-1:0] LFSR_SEED       = 8'hA5,
  parameter int unsigned       INITIAL_TARGET  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               gameActive,
  input  logic               clearScore,
  input  logic               drawBall,
  input  logic               drawScoreNumber,
  output logic [DIGIT_W-1:0] scoreNumber,
  output logic               hitPulse,
  output logic [DIGIT_W-1:0] scoreTens,
  output logic [DIGIT_W-1:0] scoreOnes
);

  // One counter serves both the timeout and the cooldown, so it covers the larger.
  localparam int unsigned CNT_MAX = (TARGET_FRAMES > COOLDOWN_FRAMES) ? TARGET_FRAMES
                                                                      : COOLDOWN_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TF_LAST = CNT_W'(TARGET_FRAMES - 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_FRAMES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DIGIT_W-1:0] target_q;
  logic               hit_q;
  logic [DIGIT_W-1:0] tens_q, ones_q;
  logic [DIGIT_W-1:0] tens_d, ones_d;
  logic [DIGIT_W-1:0] next_digit;
  logic               collide;

  assign collide = drawBall & drawScoreNumber;

  random_digit #(.LFSR_SEED(LFSR_SEED)) u_random_digit (
    .clk         (clk),
    .reset       (reset),
    .cur_digit_i (target_q),
    .next_digit_o(next_digit)
  );

  // BCD increment that saturates at 99.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (!(tens_q == DIGIT_W'(9) && ones_q == DIGIT_W'(9))) begin
      if (ones_q == DIGIT_W'(9)) begin
        ones_d = '0;
        tens_d = tens_q + DIGIT_W'(1);
      end else begin
        ones_d = ones_q + DIGIT_W'(1);
      end
    end
  end

  // Controller FSM with registered target, hit strobe and score.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= DIGIT_W'(INITIAL_TARGET);
      hit_q    <= 1'b0;
      tens_q   <= '0;
      ones_q   <= '0;
    end else begin
      hit_q <= 1'b0;
      if (!gameActive) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (startOfFrame) begin
              state_q <= ARMED;
              cnt_q   <= '0;
            end
          end
          ARMED: begin
            // A collision outranks a coincident frame pulse; that pulse is not a timeout frame.
            if (collide) begin
              state_q <= SCORED;
              hit_q   <= 1'b1;
              tens_q  <= tens_d;
              ones_q  <= ones_d;
            end else if (startOfFrame) begin
              if (cnt_q == TF_LAST) begin
                target_q <= next_digit;
                cnt_q    <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          SCORED: begin
            if (startOfFrame) begin
              target_q <= next_digit;
              cnt_q    <= '0;
              state_q  <= (COOLDOWN_FRAMES == 0) ? ARMED : COOLDOWN;
            end
          end
          COOLDOWN: begin
            if (startOfFrame) begin
              if (cnt_q == CD_LAST) begin
                state_q <= ARMED;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
      // Later assignment wins, so a clear beats a same-cycle hit.
      if (clearScore) begin
        tens_q <= '0;
        ones_q <= '0;
      end
    end
  end

  assign scoreNumber = target_q;
  assign hitPulse    = hit_q;
  assign scoreTens   = tens_q;
  assign scoreOnes   = ones_q;

endmodule

// File: tb/tb_score_target_controller.sv
// Randomized self-checking bench for score_target_controller against a
// behavioural game model (integer score, frame counting, arithmetic target pick).
module tb_score_target_controller;

  localparam int TF = 3;
  localparam int CD = 2;
  localparam int INIT_TGT = 5;
  localparam int SEED = 8'hA5;

  // Model game phases.
  localparam int WAIT_START = 0;
  localparam int LIVE       = 1;
  localparam int JUST_HIT   = 2;
  localparam int RECOVER    = 3;

  logic       clk = 1'b0;
  logic       reset, startOfFrame, gameActive, clearScore, drawBall, drawScoreNumber;
  logic [3:0] scoreNumber, scoreTens, scoreOnes;
  logic       hitPulse;

  int n_cmp = 0;
  int n_bad = 0;

  int m_tgt, m_score, m_hit, m_mode, m_frames, m_lfsr, m_hit99;
  int hit_count = 0;

  score_target_controller #(
    .TARGET_FRAMES  (TF),
    .COOLDOWN_FRAMES(CD),
    .LFSR_SEED      (8'hA5),
    .INITIAL_TARGET (INIT_TGT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .gameActive     (gameActive),
    .clearScore     (clearScore),
    .drawBall       (drawBall),
    .drawScoreNumber(drawScoreNumber),
    .scoreNumber    (scoreNumber),
    .hitPulse       (hitPulse),
    .scoreTens      (scoreTens),
    .scoreOnes      (scoreOnes)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3 shifted in at bit 0.
  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  function automatic int pick(input int l, input int cur);
    int c;
    c = l % 16;
    if (c >= 10) c = c - 6;
    if (c == cur) c = (cur + 1) % 10;
    return c;
  endfunction

  task automatic model_step(input bit rst, input bit sof, input bit ga, input bit cs, input bit col);
    if (rst) begin
      m_tgt = INIT_TGT; m_score = 0; m_hit = 0; m_mode = WAIT_START; m_frames = 0; m_lfsr = SEED;
      return;
    end
    m_hit = 0;
    if (!ga) begin
      m_mode = WAIT_START;
      m_frames = 0;
    end else begin
      case (m_mode)
        WAIT_START: if (sof) begin m_mode = LIVE; m_frames = 0; end
        LIVE: begin
          if (col) begin
            m_hit = 1;
            if (m_score == 99) m_hit99 = 1;
            else m_score = m_score + 1;
            m_mode = JUST_HIT;
          end else if (sof) begin
            m_frames++;
            if (m_frames == TF) begin m_tgt = pick(m_lfsr, m_tgt); m_frames = 0; end
          end
        end
        JUST_HIT: if (sof) begin
          m_tgt = pick(m_lfsr, m_tgt);
          m_frames = 0;
          m_mode = (CD == 0) ? LIVE : RECOVER;
        end
        default: if (sof) begin
          m_frames++;
          if (m_frames == CD) begin m_mode = LIVE; m_frames = 0; end
        end
      endcase
    end
    if (cs) m_score = 0;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // One clock: drive inputs, advance model, compare all outputs 1 ns after the edge.
  task automatic cyc(input bit rst, input bit sof, input bit ga, input bit cs,
                     input bit ball, input bit num);
    reset = rst; startOfFrame = sof; gameActive = ga; clearScore = cs;
    drawBall = ball; drawScoreNumber = num;
    model_step(rst, sof, ga, cs, ball & num);
    @(posedge clk);
    #1;
    check_val("target", 32'(scoreNumber), m_tgt);
    check_val("tens",   32'(scoreTens),   m_score / 10);
    check_val("ones",   32'(scoreOnes),   m_score % 10);
    check_val("hit",    32'(hitPulse),    m_hit);
    if (hitPulse === 1'b1) hit_count++;
  endtask

  initial begin
    logic [3:0] prev, t0;
    int changes, k, f, h0;
    m_hit99 = 0;
    reset = 1'b1; startOfFrame = 1'b0; gameActive = 1'b0; clearScore = 1'b0;
    drawBall = 1'b0; drawScoreNumber = 1'b0;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check_val("rst_target", 32'(scoreNumber), 5);
    check_val("rst_score",  32'({scoreTens, scoreOnes}), 0);
    check_val("rst_hit",    32'(hitPulse), 0);

    // IDLE must ignore collisions, with or without an inactive frame pulse.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 1, 1);
      cyc(0, 1, 0, 0, 1, 1);
    end
    check_val("idle_no_hit", 32'(hit_count), 0);

    // Arm, then a 3-cycle collision yields one hit.
    cyc(0, 1, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 1, 1);
    check_val("one_hit", 32'(hit_count), 1);
    check_val("score01", 32'({scoreTens, scoreOnes}), 8'h01);
    cyc(0, 1, 1, 0, 0, 0);
    check_val("new_target", 32'((scoreNumber != 4'd5) && (scoreNumber < 4'd10)), 1);

    // Cooldown of two frames blocks the collision in between.
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 1);
    check_val("cd_blocked", 32'({scoreTens, scoreOnes}), 8'h01);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 1);
    check_val("cd_second_hit", 32'({scoreTens, scoreOnes}), 8'h02);

    // Retarget after the hit, drain cooldown, then time out after 3 frames.
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    t0 = scoreNumber;
    cyc(0, 1, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    check_val("timeout_hold", 32'(scoreNumber), int'(t0));
    h0 = hit_count;
    cyc(0, 1, 1, 0, 0, 0);
    check_val("timeout_change", 32'(scoreNumber != t0), 1);
    check_val("timeout_score", 32'({scoreTens, scoreOnes}), 8'h02);
    check_val("timeout_nohit", 32'(hit_count), h0);

    // Random frames with collisions, clears and pauses.
    for (int fr = 0; fr < 300; fr++) begin
      bit ga;
      ga = ($urandom % 20) != 0;
      cyc(0, 1, ga, ($urandom % 40) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0);
      for (int j = 0; j < int'($urandom_range(1, 6)); j++)
        cyc(0, 0, ga, ($urandom % 60) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0);
    end

    // Drive the score to 99 and hit once more.
    cyc(0, 0, 1, 1, 0, 0);
    f = 0;
    while (!m_hit99 && f < 2000) begin
      cyc(0, 1, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 1, 1);
      f++;
    end
    check_val("sat_reached", 32'(m_hit99), 1);
    check_val("hit_at_99", 32'(hitPulse), 1);
    check_val("sat_score", 32'({scoreTens, scoreOnes}), 8'h99);
    cyc(0, 0, 1, 1, 0, 0);
    check_val("clear_score", 32'({scoreTens, scoreOnes}), 8'h00);

    // 10,000 forced timeouts.
    changes = 0;
    k = 0;
    prev = scoreNumber;
    while (changes < 10000 && k < 62000) begin
      cyc(0, (k % 2) == 0, 1, 0, 0, 0);
      if (scoreNumber !== prev) begin
        check_val("range_distinct", 32'((scoreNumber < 4'd10) && (scoreNumber != prev)), 1);
        changes++;
        prev = scoreNumber;
      end
      k++;
    end
    check_val("changes_done", 32'(changes), 10000);

    // Reset while in SCORED.
    cyc(0, 0, 1, 0, 1, 1);
    check_val("pre_reset_hit", 32'(hitPulse), 1);
    cyc(1, 0, 1, 0, 1, 1);
    check_val("mid_rst_target", 32'(scoreNumber), 5);
    check_val("mid_rst_score",  32'({scoreTens, scoreOnes}), 0);
    check_val("mid_rst_hit",    32'(hitPulse), 0);
    cyc(0, 0, 1, 0, 1, 1);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_target_controller.md
# score_target_controller

Game-logic stage that feeds `scoreNumber` into the obstacle digit row and consumes the row's `drawScoreNumber` strobe. It detects the ball touching the currently highlighted target digit, keeps a two-digit BCD score, and picks the next target pseudo-randomly. Target changes happen only at frame boundaries so the display never tears. The target also changes if it is not hit within a timeout.

## Interface
Parameters:
- `TARGET_FRAMES`, 300 — frames a target stays armed before timing out (must be ≥1).
- `COOLDOWN_FRAMES`, 30 — frames after a hit during which collisions are ignored (0 allowed).
- `LFSR_SEED`, 8'hA5 — LFSR reset value (must be nonzero).
- `INITIAL_TARGET`, 5 — `scoreNumber` value after reset (0..9).

Ports:
- `clk` in 1 — pixel clock, single clock domain.
- `reset` in 1 — synchronous, active-high reset.
- `startOfFrame` in 1 — one-cycle pulse at the first pixel of each frame.
- `gameActive` in 1 — level; low freezes the game.
- `clearScore` in 1 — one-cycle pulse; zeroes the score.
- `drawBall` in 1 — the current pixel belongs to the ball.
- `drawScoreNumber` in 1 — the current pixel belongs to the target digit.
- `scoreNumber` out 4 — current target digit, 0..9, registered.
- `hitPulse` out 1 — one-cycle pulse on each accepted hit.
- `scoreTens`, `scoreOnes` out 4 each — BCD score, registered.

## Operation
- Collision: `collide = drawBall & drawScoreNumber`, sampled each cycle.
- FSM states:
  - IDLE
    - Go to ARMED on a cycle with `startOfFrame & gameActive`; clear the frame counter.
  - ARMED
    - On `collide`: go to SCORED, pulse `hitPulse`, and increment the score.
    - Otherwise, on `startOfFrame`: increment the frame counter.
    - When the counter reaches `TARGET_FRAMES-1` at a `startOfFrame`: load a new target, clear the counter, and stay in ARMED (no score change).
  - SCORED
    - Further collisions are ignored.
    - On `startOfFrame`: load a new target and clear the counter.
    - Then go to COOLDOWN, or to ARMED if `COOLDOWN_FRAMES==0`.
  - COOLDOWN
    - Collisions are ignored; count `startOfFrame` pulses.
    - On the `COOLDOWN_FRAMES`-th pulse: go to ARMED with the counter cleared.
- `gameActive` low in any state:
  - go to IDLE next cycle and clear the counters;
  - `scoreNumber` and the score hold;
  - no `hitPulse`.
- Next-target selection:
  - `c = lfsr[3:0]`; if `c ≥ 10`, then `c = c - 6`;
  - if `c == scoreNumber`, then `c = (scoreNumber == 9) ? 0 : scoreNumber + 1`.
  - The new target is therefore always in 0..9 and always different from the current target.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. It steps every cycle that is not in reset, including in IDLE.
- Score: BCD increment (ones wrap 9→0 and carry into tens). It saturates at 99; a hit at 99 still pulses `hitPulse`.
- `clearScore` zeroes the score next cycle. If a hit lands in the same cycle, the clear wins (score = 00).

## Timing
- Reset values:
  - `scoreNumber` = `INITIAL_TARGET`, score = 00, `hitPulse` = 0;
  - state IDLE, counters 0, LFSR = `LFSR_SEED`.
- `collide` at cycle t (state ARMED): `hitPulse` is high at t+1 only; the score is updated at t+1.
- `scoreNumber` changes only in the cycle after a consumed `startOfFrame` (latency 1). It is never changed mid-frame.
- Collision and `startOfFrame` in the same ARMED cycle: the collision wins. The target updates at the next `startOfFrame`, and that same pulse is not counted as the timeout frame.
- At most one accepted hit per target.
- `reset` asserted mid-operation: all state returns to reset values on the next edge, regardless of FSM state.

## Structure
- Add to the shared `defines` package:
  - a state enum typedef (IDLE, ARMED, SCORED, COOLDOWN);
  - the constant `NUM_DIGITS = 10`.
- Sub-module `random_digit`:
  - contains the LFSR and the mod-10/exclusion logic;
  - inputs: `clk`, `reset`, current digit;
  - output: the next digit (combinational from the registered LFSR).
- Frame and cooldown counters are sized `$clog2(TARGET_FRAMES+1)`; they may share one register.

## Test plan
- Reset with defaults → `scoreNumber`=5, score 00, `hitPulse`=0. It stays in IDLE until `gameActive`=1 and `startOfFrame`.
- ARMED, `drawBall` and `drawScoreNumber` both high for 3 consecutive cycles → exactly one `hitPulse`, score 01. At the next `startOfFrame`, `scoreNumber` ≠ 5 and is in 0..9.
- `TARGET_FRAMES`=3, no collisions, 3 `startOfFrame` pulses → target changes one cycle after the 3rd pulse; score unchanged; no `hitPulse`.
- `COOLDOWN_FRAMES`=2: hit, then collisions on every frame → second hit accepted only after 2 cooldown frames (score 01→02 at the earliest allowed point).
- Score preloaded to 99 via 99 hits, then one more hit → `hitPulse`=1, score stays 99. Then `clearScore` → 00.
- Run 10,000 target changes via forced timeouts → every `scoreNumber` is in 0..9 and never repeats consecutively. Also: `reset` asserted during SCORED returns all reset values next cycle.
